// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, instruction memory addressing, and a 2-bit saturating counter branch predictor.
// Fetch is combinational from PC; the PC advances on the next edge (redirect > stall > predicted target > PC+1).
module instruction_fetch_stage #(
  parameter int                    InstrWidth   = 16,
  parameter int                    IndexBits    = 4,
  parameter logic [InstrWidth-1:0] ResetPC      = '0,
  parameter logic [3:0]            BranchOpcode = 4'b1100
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Stall,
  input  logic                  Redirect_Valid,
  input  logic [InstrWidth-1:0] Redirect_PC,
  input  logic                  Update_Valid,
  input  logic [InstrWidth-1:0] Update_PC,
  input  logic                  Update_Taken,
  output logic [InstrWidth-1:0] Imem_Addr,
  input  logic [InstrWidth-1:0] Imem_Data,
  output logic [InstrWidth-1:0] Instruction_Out,
  output logic [InstrWidth-1:0] PC_Out,
  output logic                  Branch_Taken_Out
);

  localparam int Entries = 1 << IndexBits;

  logic [InstrWidth-1:0] pc_q, pc_d;
  logic [1:0]            cnt_q [Entries];
  logic [1:0]            cnt_d [Entries];

  logic                  is_branch;
  logic [IndexBits-1:0]  rd_idx;
  logic [IndexBits-1:0]  upd_idx;
  logic [InstrWidth-1:0] offset;
  logic [InstrWidth-1:0] pc_inc;
  logic [InstrWidth-1:0] target;
  logic                  unused_bits;

  assign is_branch        = (Imem_Data[15:12] == BranchOpcode);
  assign rd_idx           = pc_q[IndexBits-1:0];
  assign upd_idx          = Update_PC[IndexBits-1:0];
  assign Branch_Taken_Out = is_branch & cnt_q[rd_idx][1];

  // Offset is relative to the following instruction; all arithmetic wraps.
  assign offset = {{(InstrWidth-8){Imem_Data[7]}}, Imem_Data[7:0]};
  assign pc_inc = pc_q + InstrWidth'(1);
  assign target = pc_inc + offset;

  assign Imem_Addr       = pc_q;
  assign PC_Out          = pc_q;
  assign Instruction_Out = Imem_Data;

  assign unused_bits = ^{Update_PC[InstrWidth-1:IndexBits], Imem_Data[11:8]};

  always_comb begin
    pc_d = pc_inc;
    if (Redirect_Valid) begin
      pc_d = Redirect_PC;
    end else if (Stall) begin
      pc_d = pc_q;
    end else if (Branch_Taken_Out) begin
      pc_d = target;
    end
  end

  // Prediction above reads cnt_q, so a same-index update only becomes visible next cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (Update_Valid) begin
      if (Update_Taken && (cnt_q[upd_idx] != 2'b11)) begin
        cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
      end else if (!Update_Taken && (cnt_q[upd_idx] != 2'b00)) begin
        cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q <= ResetPC;
      for (int i = 0; i < Entries; i++) begin
        cnt_q[i] <= 2'b01;
      end
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a reference model and a next-PC scoreboard queue.
module tb_instruction_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Stall = 1'b0;
  logic        Redirect_Valid = 1'b0;
  logic [15:0] Redirect_PC = '0;
  logic        Update_Valid = 1'b0;
  logic [15:0] Update_PC = '0;
  logic        Update_Taken = 1'b0;
  logic [15:0] Imem_Addr;
  logic [15:0] Imem_Data = '0;
  logic [15:0] Instruction_Out;
  logic [15:0] PC_Out;
  logic        Branch_Taken_Out;

  instruction_fetch_stage dut (
    .CLK              (CLK),
    .RST              (RST),
    .Stall            (Stall),
    .Redirect_Valid   (Redirect_Valid),
    .Redirect_PC      (Redirect_PC),
    .Update_Valid     (Update_Valid),
    .Update_PC        (Update_PC),
    .Update_Taken     (Update_Taken),
    .Imem_Addr        (Imem_Addr),
    .Imem_Data        (Imem_Data),
    .Instruction_Out  (Instruction_Out),
    .PC_Out           (PC_Out),
    .Branch_Taken_Out (Branch_Taken_Out)
  );

  always #5 CLK = ~CLK;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_pc;
  logic [1:0]  m_cnt [16];
  logic        m_known = 1'b0;
  logic        last_bt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs against the model,
  // push the expected next PC, clock, then pop and compare.
  task automatic cyc(input logic rst, input logic stall, input logic rv, input logic [15:0] rpc,
                     input logic uv, input logic [15:0] upc, input logic ut, input logic [15:0] data);
    logic        bt;
    logic [15:0] nxt;
    logic [15:0] tgt;
    RST = rst; Stall = stall; Redirect_Valid = rv; Redirect_PC = rpc;
    Update_Valid = uv; Update_PC = upc; Update_Taken = ut; Imem_Data = data;
    #1;
    last_bt = Branch_Taken_Out;
    chk("instr_out", Instruction_Out, data);
    if (m_known) begin
      bt  = (data[15:12] == 4'hC) && m_cnt[m_pc[3:0]][1];
      tgt = m_pc + 16'd1 + {{8{data[7]}}, data[7:0]};
      chk("imem_addr", Imem_Addr, m_pc);
      chk("pc_out", PC_Out, m_pc);
      chk("pred", {15'd0, Branch_Taken_Out}, {15'd0, bt});
      if (rst)        nxt = 16'h0000;
      else if (rv)    nxt = rpc;
      else if (stall) nxt = m_pc;
      else if (bt)    nxt = tgt;
      else            nxt = m_pc + 16'd1;
      exp_q.push_back(nxt);
    end else if (rst) begin
      exp_q.push_back(16'h0000);
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = 2'b01;
      m_known = 1'b1;
      m_pc = 16'h0000;
    end else begin
      if (uv) begin
        if (ut && m_cnt[upc[3:0]] != 2'b11)       m_cnt[upc[3:0]] = m_cnt[upc[3:0]] + 2'd1;
        else if (!ut && m_cnt[upc[3:0]] != 2'b00) m_cnt[upc[3:0]] = m_cnt[upc[3:0]] - 2'd1;
      end
      if (m_known) m_pc = nxt;
    end
    @(posedge CLK);
    #2;
    if (exp_q.size() > 0) chk("next_pc", PC_Out, exp_q.pop_front());
  endtask

  task automatic go(input logic [15:0] data);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 0, data);
  endtask

  task automatic jump(input logic [15:0] pc);
    cyc(0, 0, 1, pc, 0, 16'h0, 0, 16'h0000);
  endtask

  initial begin
    // Reset then sequential fetch
    cyc(1, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0000);
    chk("rst_pc", PC_Out, 16'h0000);
    chk("rst_addr", Imem_Addr, 16'h0000);
    go(16'h0000); chk("seq1", PC_Out, 16'h0001);
    go(16'h0000); chk("seq2", PC_Out, 16'h0002);
    go(16'h0000); chk("seq3", PC_Out, 16'h0003);

    // Cold branch, training, refetch
    jump(16'h0005);
    go(16'hC004);
    chk("cold_pred", {15'd0, last_bt}, 16'h0000);
    chk("cold_next", PC_Out, 16'h0006);
    cyc(0, 0, 0, 16'h0, 1, 16'h0005, 1, 16'h0000);
    cyc(0, 0, 0, 16'h0, 1, 16'h0005, 1, 16'h0000);
    jump(16'h0005);
    go(16'hC004);
    chk("trained_pred", {15'd0, last_bt}, 16'h0001);
    chk("trained_next", PC_Out, 16'h000A);

    // Negative offset and wrap
    cyc(0, 0, 1, 16'h0010, 1, 16'h0000, 1, 16'h0000);
    go(16'hC0FE);
    chk("neg_next", PC_Out, 16'h000F);
    jump(16'hFFFF);
    go(16'h1234);
    chk("wrap_next", PC_Out, 16'h0000);

    // Stall vs redirect
    jump(16'h0007);
    cyc(0, 1, 0, 16'h0, 0, 16'h0, 0, 16'hC001);
    chk("stall1", PC_Out, 16'h0007);
    cyc(0, 1, 0, 16'h0, 0, 16'h0, 0, 16'hC001);
    chk("stall2", PC_Out, 16'h0007);
    cyc(0, 1, 1, 16'h0040, 0, 16'h0, 0, 16'h0000);
    chk("stall_redirect", PC_Out, 16'h0040);

    // Saturation at 00 on index 3, then same-cycle read/update
    cyc(0, 0, 1, 16'h0023, 1, 16'h0003, 1, 16'h0000);
    cyc(0, 0, 0, 16'h0, 1, 16'h0003, 0, 16'h0000);
    cyc(0, 0, 0, 16'h0, 1, 16'h0003, 0, 16'h0000);
    cyc(0, 0, 0, 16'h0, 1, 16'h0003, 0, 16'h0000);
    cyc(0, 0, 0, 16'h0, 1, 16'h0003, 1, 16'h0000);
    jump(16'h0033);
    cyc(0, 0, 0, 16'h0, 1, 16'h0003, 1, 16'hC005);
    chk("sat_low_pred", {15'd0, last_bt}, 16'h0000);
    chk("same_cycle_next", PC_Out, 16'h0034);
    jump(16'h0043);
    go(16'hC005);
    chk("post_update_pred", {15'd0, last_bt}, 16'h0001);
    chk("post_update_next", PC_Out, 16'h0049);

    // Saturation at 11: extra taken updates, then one not-taken keeps it taken
    cyc(0, 0, 0, 16'h0, 1, 16'h0005, 1, 16'h0000);
    cyc(0, 0, 0, 16'h0, 1, 16'h0005, 0, 16'h0000);
    jump(16'h0015);
    go(16'hC002);
    chk("sat_high_pred", {15'd0, last_bt}, 16'h0001);

    // Reset mid-run overrides redirect and update
    cyc(1, 1, 1, 16'h0077, 1, 16'h0005, 0, 16'h0000);
    chk("rst_mid_pc", PC_Out, 16'h0000);
    go(16'hC003);
    chk("rst_cnt0_pred", {15'd0, last_bt}, 16'h0000);
    chk("rst_cnt0_next", PC_Out, 16'h0001);
    jump(16'h0005);
    go(16'hC004);
    chk("rst_cnt5_pred", {15'd0, last_bt}, 16'h0000);
    chk("rst_cnt5_next", PC_Out, 16'h0006);

    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
